// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs and EX-side outputs of the ID/EX pipeline stage.
// master drives decode fields; slave is the stage itself.
interface id_ex_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CTRL_W = 8
);
   logic              stall;
   logic              flush;
   logic              in_valid;
   logic [REG_AW-1:0] in_rs;
   logic [REG_AW-1:0] in_rt;
   logic [REG_AW-1:0] in_rd;
   logic [DATA_W-1:0] in_imm;
   logic [CTRL_W-1:0] in_ctrl;
   logic              in_mem_read;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;
   logic              wb_write;
   logic [REG_AW-1:0] wb_WR;
   logic [DATA_W-1:0] wb_WD;
   logic              hazard_stall;
   logic              out_valid;
   logic [DATA_W-1:0] out_A;
   logic [DATA_W-1:0] out_B;
   logic [REG_AW-1:0] out_rs;
   logic [REG_AW-1:0] out_rt;
   logic [REG_AW-1:0] out_rd;
   logic [DATA_W-1:0] out_imm;
   logic [CTRL_W-1:0] out_ctrl;
   logic              out_mem_read;

   modport master (
      output stall, flush, in_valid, in_rs, in_rt, in_rd, in_imm, in_ctrl, in_mem_read,
             RD1, RD2, wb_write, wb_WR, wb_WD,
      input  hazard_stall, out_valid, out_A, out_B, out_rs, out_rt, out_rd,
             out_imm, out_ctrl, out_mem_read
   );

   modport slave (
      input  stall, flush, in_valid, in_rs, in_rt, in_rd, in_imm, in_ctrl, in_mem_read,
             RD1, RD2, wb_write, wb_WR, wb_WD,
      output hazard_stall, out_valid, out_A, out_B, out_rs, out_rt, out_rd,
             out_imm, out_ctrl, out_mem_read
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use hazard detection,
// external hold and flush-to-bubble.
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CTRL_W = 8
) (
   input logic           clk,
   input logic           reset,
   id_ex_stage_if.slave  bus
);
   logic              r_valid;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [REG_AW-1:0] r_rs;
   logic [REG_AW-1:0] r_rt;
   logic [REG_AW-1:0] r_rd;
   logic [DATA_W-1:0] r_imm;
   logic [CTRL_W-1:0] r_ctrl;
   logic              r_mem_read;

   logic [DATA_W-1:0] w_a_next;
   logic [DATA_W-1:0] w_b_next;
   logic              w_hazard;

   // Same-cycle write-back overrides stale register-file data; r0 is hardwired.
   always_comb begin
      w_a_next = bus.RD1;
      w_b_next = bus.RD2;
      if (bus.wb_write && (bus.wb_WR == bus.in_rs) && (bus.in_rs != '0)) w_a_next = bus.wb_WD;
      if (bus.wb_write && (bus.wb_WR == bus.in_rt) && (bus.in_rt != '0)) w_b_next = bus.wb_WD;
   end

   // Load in EX whose destination is a source of the instruction in decode.
   always_comb begin
      w_hazard = 1'b0;
      if (!reset && r_valid && r_mem_read && bus.in_valid && (r_rt != '0) &&
          ((r_rt == bus.in_rs) || (r_rt == bus.in_rt)))
         w_hazard = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset || bus.flush || (!bus.stall && w_hazard)) begin
         r_valid    <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_imm      <= '0;
         r_ctrl     <= '0;
         r_mem_read <= 1'b0;
      end else if (!bus.stall) begin
         r_valid    <= bus.in_valid;
         r_a        <= w_a_next;
         r_b        <= w_b_next;
         r_rs       <= bus.in_rs;
         r_rt       <= bus.in_rt;
         r_rd       <= bus.in_rd;
         r_imm      <= bus.in_imm;
         r_ctrl     <= bus.in_ctrl;
         r_mem_read <= bus.in_mem_read;
      end
   end

   assign bus.hazard_stall = w_hazard;
   assign bus.out_valid    = r_valid;
   assign bus.out_A        = r_a;
   assign bus.out_B        = r_b;
   assign bus.out_rs       = r_rs;
   assign bus.out_rt       = r_rt;
   assign bus.out_rd       = r_rd;
   assign bus.out_imm      = r_imm;
   assign bus.out_ctrl     = r_ctrl;
   assign bus.out_mem_read = r_mem_read;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// behavioural model of the EX slot.
module tb_id_ex_stage;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CTRL_W = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) bus ();

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model of the EX slot contents.
   logic              m_valid = 1'b0;
   logic [DATA_W-1:0] m_a = '0;
   logic [DATA_W-1:0] m_b = '0;
   logic [REG_AW-1:0] m_rs = '0;
   logic [REG_AW-1:0] m_rt = '0;
   logic [REG_AW-1:0] m_rd = '0;
   logic [DATA_W-1:0] m_imm = '0;
   logic [CTRL_W-1:0] m_ctrl = '0;
   logic              m_mem_read = 1'b0;

   function automatic logic model_hazard();
      if (reset) return 1'b0;
      return m_valid && m_mem_read && bus.in_valid && (m_rt != 0) &&
             ((m_rt == bus.in_rs) || (m_rt == bus.in_rt));
   endfunction

   function automatic void model_bubble();
      m_valid = 1'b0; m_a = '0; m_b = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      m_imm = '0; m_ctrl = '0; m_mem_read = 1'b0;
   endfunction

   function automatic void model_step();
      logic haz;
      haz = model_hazard();
      if (reset || bus.flush) model_bubble();
      else if (bus.stall) begin end
      else if (haz) model_bubble();
      else begin
         m_valid    = bus.in_valid;
         m_a        = (bus.wb_write && bus.wb_WR == bus.in_rs && bus.in_rs != 0) ? bus.wb_WD : bus.RD1;
         m_b        = (bus.wb_write && bus.wb_WR == bus.in_rt && bus.in_rt != 0) ? bus.wb_WD : bus.RD2;
         m_rs       = bus.in_rs;
         m_rt       = bus.in_rt;
         m_rd       = bus.in_rd;
         m_imm      = bus.in_imm;
         m_ctrl     = bus.in_ctrl;
         m_mem_read = bus.in_mem_read;
      end
   endfunction

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b1;
      bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
      bus.in_imm = '0; bus.in_ctrl = '0; bus.in_mem_read = 1'b0;
      bus.RD1 = '0; bus.RD2 = '0;
      bus.wb_write = 1'b0; bus.wb_WR = '0; bus.wb_WD = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      bus.RD1 = 32'd6; bus.in_rs = 5'd6; bus.in_imm = 32'hdead_beef; bus.in_ctrl = 8'h5a;
      bus.in_mem_read = 1'b1; bus.in_rt = 5'd3;
      #1;
      n_vec++;
      if (bus.hazard_stall !== 1'b0) begin
         n_err++; $display("FAIL reset_hazard got %b want 0", bus.hazard_stall);
      end
      cyc();
      n_vec++;
      if ({bus.out_valid, bus.out_A, bus.out_B, bus.out_rs, bus.out_rt, bus.out_rd,
           bus.out_imm, bus.out_ctrl, bus.out_mem_read} !== '0) begin
         n_err++; $display("FAIL reset_outputs valid=%b A=%h imm=%h ctrl=%h want all 0",
                           bus.out_valid, bus.out_A, bus.out_imm, bus.out_ctrl);
      end
      reset = 1'b0;
      idle_inputs();
      bus.in_rs = 5'd6; bus.in_rt = 5'd8; bus.RD1 = 32'd6; bus.RD2 = 32'd8;
      cyc();
      n_vec++;
      if (bus.out_A !== 32'd6 || bus.out_B !== 32'd8 || bus.out_valid !== 1'b1) begin
         n_err++; $display("FAIL first_load A=%0d B=%0d valid=%b want 6 8 1",
                           bus.out_A, bus.out_B, bus.out_valid);
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      bus.wb_write = 1'b1; bus.wb_WR = 5'd4; bus.wb_WD = 32'd31;
      bus.in_rs = 5'd4; bus.RD1 = 32'd4; bus.in_rt = 5'd9; bus.RD2 = 32'd77;
      cyc();
      n_vec++;
      if (bus.out_A !== 32'd31 || bus.out_B !== 32'd77) begin
         n_err++; $display("FAIL bypass_rs A=%0d B=%0d want 31 77", bus.out_A, bus.out_B);
      end
      bus.wb_WR = 5'd9; bus.in_rs = 5'd2; bus.RD1 = 32'd55;
      cyc();
      n_vec++;
      if (bus.out_A !== 32'd55 || bus.out_B !== 32'd31) begin
         n_err++; $display("FAIL bypass_rt A=%0d B=%0d want 55 31", bus.out_A, bus.out_B);
      end
      bus.wb_WR = 5'd0; bus.in_rs = 5'd0; bus.RD1 = 32'd123; bus.in_rt = 5'd0; bus.RD2 = 32'd0;
      cyc();
      n_vec++;
      if (bus.out_A !== 32'd123 || bus.out_B !== 32'd0) begin
         n_err++; $display("FAIL bypass_r0 A=%0d B=%0d want 123 0", bus.out_A, bus.out_B);
      end
   endtask

   task automatic test_load_use();
      idle_inputs();
      bus.in_mem_read = 1'b1; bus.in_rt = 5'd10; bus.in_rs = 5'd3; bus.in_rd = 5'd10;
      cyc();
      bus.in_mem_read = 1'b0; bus.in_rs = 5'd10; bus.in_rt = 5'd1; bus.RD1 = 32'd10;
      bus.in_ctrl = 8'h33;
      #1;
      n_vec++;
      if (bus.hazard_stall !== 1'b1) begin
         n_err++; $display("FAIL load_use_detect hazard=%b want 1", bus.hazard_stall);
      end
      cyc();
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.out_mem_read !== 1'b0 || bus.out_ctrl !== 8'h00) begin
         n_err++; $display("FAIL load_use_bubble valid=%b mr=%b ctrl=%h want 0 0 00",
                           bus.out_valid, bus.out_mem_read, bus.out_ctrl);
      end
      n_vec++;
      if (bus.hazard_stall !== 1'b0) begin
         n_err++; $display("FAIL load_use_clear hazard=%b want 0", bus.hazard_stall);
      end
      cyc();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_A !== 32'd10 || bus.out_ctrl !== 8'h33) begin
         n_err++; $display("FAIL load_use_replay valid=%b A=%0d ctrl=%h want 1 10 33",
                           bus.out_valid, bus.out_A, bus.out_ctrl);
      end
   endtask

   task automatic test_stall_hold();
      idle_inputs();
      bus.in_rs = 5'd12; bus.RD1 = 32'd12;
      cyc();
      bus.stall = 1'b1; bus.RD1 = 32'd99;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_vec++;
         if (bus.out_A !== 32'd12 || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_hold[%0d] A=%0d valid=%b want 12 1",
                              i, bus.out_A, bus.out_valid);
         end
      end
      bus.stall = 1'b0;
      cyc();
      n_vec++;
      if (bus.out_A !== 32'd99) begin
         n_err++; $display("FAIL stall_release A=%0d want 99", bus.out_A);
      end
   endtask

   task automatic test_flush_priority();
      idle_inputs();
      bus.in_ctrl = 8'hc3; bus.RD1 = 32'd5;
      cyc();
      bus.flush = 1'b1; bus.stall = 1'b1;
      cyc();
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 8'h00 || bus.out_A !== 32'd0) begin
         n_err++; $display("FAIL flush_over_stall valid=%b ctrl=%h A=%0d want 0 00 0",
                           bus.out_valid, bus.out_ctrl, bus.out_A);
      end
      idle_inputs();
      bus.in_ctrl = 8'h7e; bus.RD1 = 32'd44; bus.in_rd = 5'd17; bus.in_imm = 32'd900;
      cyc();
      bus.stall = 1'b1;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n_vec++;
      if ({bus.out_valid, bus.out_A, bus.out_B, bus.out_rs, bus.out_rt, bus.out_rd,
           bus.out_imm, bus.out_ctrl, bus.out_mem_read} !== '0) begin
         n_err++; $display("FAIL reset_during_stall valid=%b A=%0d rd=%0d imm=%0d want all 0",
                           bus.out_valid, bus.out_A, bus.out_rd, bus.out_imm);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 49) == 0);
         bus.flush       = ($urandom_range(0, 11) == 0);
         bus.stall       = ($urandom_range(0, 5) == 0);
         bus.in_valid    = ($urandom_range(0, 4) != 0);
         bus.in_rs       = REG_AW'($urandom_range(0, 3));
         bus.in_rt       = REG_AW'($urandom_range(0, 3));
         bus.in_rd       = REG_AW'($urandom);
         bus.in_imm      = DATA_W'($urandom);
         bus.in_ctrl     = CTRL_W'($urandom);
         bus.in_mem_read = ($urandom_range(0, 2) == 0);
         bus.RD1         = DATA_W'($urandom);
         bus.RD2         = DATA_W'($urandom);
         bus.wb_write    = $urandom_range(0, 1) == 1;
         bus.wb_WR       = REG_AW'($urandom_range(0, 3));
         bus.wb_WD       = DATA_W'($urandom);
         #1;
         n_vec++;
         if (bus.hazard_stall !== model_hazard()) begin
            n_err++; $display("FAIL rand_hazard[%0d] got %b want %b", i, bus.hazard_stall, model_hazard());
         end
         cyc();
         n_vec++;
         if ({bus.out_valid, bus.out_A, bus.out_B, bus.out_rs, bus.out_rt, bus.out_rd,
              bus.out_imm, bus.out_ctrl, bus.out_mem_read} !==
             {m_valid, m_a, m_b, m_rs, m_rt, m_rd, m_imm, m_ctrl, m_mem_read}) begin
            n_err++;
            $display("FAIL rand_slot[%0d] got v=%b A=%h B=%h rs=%0d rt=%0d rd=%0d imm=%h c=%h mr=%b want v=%b A=%h B=%h rs=%0d rt=%0d rd=%0d imm=%h c=%h mr=%b",
                     i, bus.out_valid, bus.out_A, bus.out_B, bus.out_rs, bus.out_rt, bus.out_rd,
                     bus.out_imm, bus.out_ctrl, bus.out_mem_read,
                     m_valid, m_a, m_b, m_rs, m_rt, m_rd, m_imm, m_ctrl, m_mem_read);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_bypass();
      test_load_use();
      test_stall_hold();
      test_flush_priority();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
